// File: rtl/mure_block_unpacker.sv
// mure_block_unpacker: buffers N-lane retirement groups and replays them one block per cycle, lane 0 first.
// Optional MURE_UNPACK_STATS_EN adds saturating block/drop counters.
module mure_block_unpacker #(
  parameter int N = 2,
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN = 3,
  parameter int CAUSE_LEN = 5,
  parameter int PRIV_LEN = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N-1:0]             valid_i,
  input  logic [N*IRETIRE_LEN-1:0] iretire_i,
  input  logic [N-1:0]             ilastsize_i,
  input  logic [N*ITYPE_LEN-1:0]   itype_i,
  input  logic [N*CAUSE_LEN-1:0]   cause_i,
  input  logic [N*XLEN-1:0]        tval_i,
  input  logic [N*PRIV_LEN-1:0]    priv_i,
  input  logic [N*XLEN-1:0]        iaddr_i,
  output logic                     ready_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [IRETIRE_LEN-1:0]   iretire_o,
  output logic                     ilastsize_o,
  output logic [ITYPE_LEN-1:0]     itype_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic [XLEN-1:0]          iaddr_o,
  output logic [XLEN-1:0]          lastaddr_o,
  output logic [$clog2(N)-1:0]     lane_o,
  output logic                     group_last_o,
  output logic                     overflow_o,
  output logic                     proto_err_o,
  output logic [31:0]              blk_cnt_o,
  output logic [31:0]              drop_cnt_o
);
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(N);
  localparam int BW = IRETIRE_LEN + 1 + ITYPE_LEN + CAUSE_LEN + XLEN + PRIV_LEN + XLEN;
  logic [N-1:0][BW-1:0] in_grp, head;
  logic [N-1:0][BW-1:0] mem [DEPTH];
  logic [CW-1:0] mem_cnt [DEPTH];
  logic [CW-1:0] cnt, hcnt;
  logic [AW:0] wp, rp;
  logic [LW-1:0] ptr;
  logic bad, run, empty, full, have, load, take, last, pop, push;
  logic [BW-1:0] cur;
  logic [IRETIRE_LEN-1:0] c_iretire;
  logic c_ls;
  logic [ITYPE_LEN-1:0] c_itype;
  logic [CAUSE_LEN-1:0] c_cause;
  logic [XLEN-1:0] c_tval, c_iaddr, la;
  logic [PRIV_LEN-1:0] c_priv;
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign in_grp[g] = {iretire_i[g*IRETIRE_LEN +: IRETIRE_LEN], ilastsize_i[g],
                        itype_i[g*ITYPE_LEN +: ITYPE_LEN], cause_i[g*CAUSE_LEN +: CAUSE_LEN],
                        tval_i[g*XLEN +: XLEN], priv_i[g*PRIV_LEN +: PRIV_LEN], iaddr_i[g*XLEN +: XLEN]};
  end
  // Only the contiguous run of valid lanes from lane 0 forms the group.
  always_comb begin
    cnt = '0;
    bad = 1'b0;
    run = 1'b1;
    for (int l = 0; l < N; l++) begin
      if (valid_i[l] && run) cnt = cnt + CW'(1);
      else begin
        bad = bad | valid_i[l];
        run = 1'b0;
      end
    end
  end
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign ready_o = !full;
  // An empty FIFO bypasses the incoming group straight to the output register.
  assign head = empty ? in_grp : mem[rp[AW-1:0]];
  assign hcnt = empty ? cnt : mem_cnt[rp[AW-1:0]];
  assign cur = head[ptr];
  assign {c_iretire, c_ls, c_itype, c_cause, c_tval, c_priv, c_iaddr} = cur;
  assign have = !empty || valid_i[0];
  assign load = !valid_o || ready_i;
  assign take = load && have;
  assign last = (CW'(ptr) + CW'(1)) == hcnt;
  assign pop = take && last && !empty;
  assign push = valid_i[0] && !full && !(empty && take && last);
  assign la = c_iretire == '0 ? c_iaddr
            : c_iaddr + (XLEN'(c_iretire) << 1) - (c_ls ? XLEN'(4) : XLEN'(2));
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wp[AW-1:0]] <= in_grp;
      mem_cnt[wp[AW-1:0]] <= cnt;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      ptr <= '0;
      valid_o <= 1'b0;
      iretire_o <= '0;
      ilastsize_o <= 1'b0;
      itype_o <= '0;
      cause_o <= '0;
      tval_o <= '0;
      priv_o <= '0;
      iaddr_o <= '0;
      lastaddr_o <= '0;
      lane_o <= '0;
      group_last_o <= 1'b0;
      overflow_o <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      overflow_o <= overflow_o | (valid_i[0] & full);
      proto_err_o <= proto_err_o | bad;
      if (load) valid_o <= have;
      if (take) begin
        ptr <= last ? '0 : ptr + LW'(1);
        iretire_o <= c_iretire;
        ilastsize_o <= c_ls;
        itype_o <= c_itype;
        cause_o <= c_cause;
        tval_o <= c_tval;
        priv_o <= c_priv;
        iaddr_o <= c_iaddr;
        lastaddr_o <= la;
        lane_o <= ptr;
        group_last_o <= last;
      end
    end
  end
`ifdef MURE_UNPACK_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (valid_o && ready_i && !(&blk_cnt_o)) blk_cnt_o <= blk_cnt_o + 32'd1;
      if (valid_i[0] && full && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 32'd1;
    end
  end
`else
  assign blk_cnt_o = '0;
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mure_block_unpacker.sv
// tb_mure_block_unpacker: directed vectors, corner sequences and random traffic against a queue-based model.
module tb_mure_block_unpacker;
  logic clk = 0, rst_n = 0, ready = 1;
  logic [1:0] valid = 0, ls = 0;
  logic [63:0] iretire = 0, tval = 0, iaddr = 0;
  logic [5:0] itype = 0;
  logic [9:0] cause = 0;
  logic [3:0] priv = 0;
  logic ready_o, valid_o, ilastsize_o, group_last_o, overflow_o, proto_err_o;
  logic [31:0] iretire_o, tval_o, iaddr_o, lastaddr_o, blk_cnt_o, drop_cnt_o;
  logic [2:0] itype_o;
  logic [4:0] cause_o;
  logic [1:0] priv_o;
  logic [0:0] lane_o;
  int checks = 0, errors = 0, hs;
  always #5 clk = ~clk;

  mure_block_unpacker dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .iretire_i(iretire), .ilastsize_i(ls),
    .itype_i(itype), .cause_i(cause), .tval_i(tval), .priv_i(priv), .iaddr_i(iaddr),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready), .iretire_o(iretire_o),
    .ilastsize_o(ilastsize_o), .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o),
    .priv_o(priv_o), .iaddr_o(iaddr_o), .lastaddr_o(lastaddr_o), .lane_o(lane_o),
    .group_last_o(group_last_o), .overflow_o(overflow_o), .proto_err_o(proto_err_o),
    .blk_cnt_o(blk_cnt_o), .drop_cnt_o(drop_cnt_o));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] iretire, tval, iaddr;
    logic ls;
    logic [2:0] itype;
    logic [4:0] cause;
    logic [1:0] priv;
    logic lane;
  } blk_t;
  typedef struct packed { int n; int taken; blk_t b1; blk_t b0; } grp_t;

  // Model: a queue of groups whose lanes have not all been moved to the output register yet.
  grp_t gq [$];
  grp_t g;
  blk_t m_blk;
  bit m_v = 0, m_last = 0, m_ovf = 0, m_perr = 0, fullq;
  longint m_bc = 0, m_dc = 0;
  int n;

  function automatic blk_t mk(int l);
    blk_t b;
    b.iretire = iretire[l*32 +: 32];
    b.tval = tval[l*32 +: 32];
    b.iaddr = iaddr[l*32 +: 32];
    b.ls = ls[l];
    b.itype = itype[l*3 +: 3];
    b.cause = cause[l*5 +: 5];
    b.priv = priv[l*2 +: 2];
    b.lane = l[0];
    return b;
  endfunction

  function automatic logic [31:0] last_addr(blk_t b);
    return b.iretire == 0 ? b.iaddr : b.iaddr + 32'd2 * b.iretire - (b.ls ? 32'd4 : 32'd2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gq.delete();
      m_v = 0; m_last = 0; m_ovf = 0; m_perr = 0; m_bc = 0; m_dc = 0;
    end else begin
      fullq = gq.size() == 4;
      if (m_v && ready && m_bc != 64'hffffffff) m_bc++;
      n = valid[0] ? (valid[1] ? 2 : 1) : 0;
      if (valid == 2'b10) m_perr = 1;
      if (n > 0) begin
        if (fullq) begin
          m_ovf = 1;
          if (m_dc != 64'hffffffff) m_dc++;
        end else begin
          g.n = n; g.taken = 0; g.b0 = mk(0); g.b1 = mk(1);
          gq.push_back(g);
        end
      end
      if (!m_v || ready) begin
        if (gq.size() > 0) begin
          g = gq[0];
          m_blk = g.taken == 0 ? g.b0 : g.b1;
          g.taken++;
          m_last = g.taken == g.n;
          if (m_last) void'(gq.pop_front());
          else gq[0] = g;
          m_v = 1;
        end else m_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid_o", valid_o, m_v);
    chk("ready_o", ready_o, gq.size() != 4);
    chk("overflow_o", overflow_o, m_ovf);
    chk("proto_err_o", proto_err_o, m_perr);
`ifdef MURE_UNPACK_STATS_EN
    chk("blk_cnt_o", blk_cnt_o, m_bc);
    chk("drop_cnt_o", drop_cnt_o, m_dc);
`else
    chk("blk_cnt_o", blk_cnt_o, 0);
    chk("drop_cnt_o", drop_cnt_o, 0);
`endif
    if (m_v && valid_o) begin
      chk("lastaddr_o", lastaddr_o, last_addr(m_blk));
      chk("iaddr_o", iaddr_o, m_blk.iaddr);
      chk("iretire_o", iretire_o, m_blk.iretire);
      chk("tval_o", tval_o, m_blk.tval);
      chk("ilastsize_o", ilastsize_o, m_blk.ls);
      chk("itype_o", itype_o, m_blk.itype);
      chk("cause_o", cause_o, m_blk.cause);
      chk("priv_o", priv_o, m_blk.priv);
      chk("lane_o", lane_o, m_blk.lane);
      chk("group_last_o", group_last_o, m_last);
    end
  end

  typedef struct packed {
    logic [1:0] v;
    logic [31:0] a0, a1, r0, r1;
    logic [1:0] ls;
    logic [31:0] e0, e1;
  } vec_t;
  vec_t tv [5];

  task automatic pulse_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    tv[0] = '{2'b11, 32'h1000, 32'h2000, 32'd4, 32'd3, 2'b01, 32'h1004, 32'h2004};
    tv[1] = '{2'b01, 32'h80, 32'h0, 32'd0, 32'd0, 2'b00, 32'h80, 32'h0};
    tv[2] = '{2'b11, 32'hfffffffe, 32'h10, 32'd1, 32'd0, 2'b10, 32'hfffffffe, 32'h10};
    tv[3] = '{2'b01, 32'hfffffffc, 32'h0, 32'd4, 32'd0, 2'b01, 32'h0, 32'h0};
    tv[4] = '{2'b11, 32'h0, 32'h100, 32'd1, 32'd1, 2'b11, 32'hfffffffe, 32'hfe};
    repeat (2) @(negedge clk);
    chk("reset valid_o", valid_o, 0);
    chk("reset ready_o", ready_o, 1);
    chk("reset lastaddr_o", lastaddr_o, 0);
    chk("reset iaddr_o", iaddr_o, 0);
    chk("reset group_last_o", group_last_o, 0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      valid = tv[i].v; iaddr = {tv[i].a1, tv[i].a0}; iretire = {tv[i].r1, tv[i].r0}; ls = tv[i].ls;
      @(negedge clk);
      valid = 0;
      chk("vec lane0 valid", valid_o, 1);
      chk("vec lane0 lastaddr", lastaddr_o, tv[i].e0);
      chk("vec lane0 group_last", group_last_o, tv[i].v != 2'b11);
      @(negedge clk);
      if (tv[i].v == 2'b11) begin
        chk("vec lane1 valid", valid_o, 1);
        chk("vec lane1 lastaddr", lastaddr_o, tv[i].e1);
        chk("vec lane1 group_last", group_last_o, 1);
      end else chk("vec single drained", valid_o, 0);
      @(negedge clk);
    end
    // Stall downstream while pushing a group every cycle.
    pulse_reset();
    ready = 0;
    for (int i = 0; i < 10; i++) begin
      valid = 2'b11; iretire = {32'd1, 32'd1}; ls = 0;
      iaddr = {32'h1008 + 32'(i) * 16, 32'h1000 + 32'(i) * 16};
      @(negedge clk);
    end
    valid = 0;
    chk("stall overflow", overflow_o, 1);
    chk("stall ready_o", ready_o, 0);
    chk("stall held iaddr", iaddr_o, 32'h1000);
    ready = 1;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_o) hs++;
      @(negedge clk);
    end
    chk("stall blocks emitted", hs, 8);
`ifdef MURE_UNPACK_STATS_EN
    chk("stats blk_cnt", blk_cnt_o, 8);
    chk("stats drop_cnt", drop_cnt_o, 6);
`else
    chk("stats blk_cnt", blk_cnt_o, 0);
    chk("stats drop_cnt", drop_cnt_o, 0);
`endif
    valid = 2'b10;
    @(negedge clk);
    valid = 0;
    chk("proto no push", valid_o, 0);
    chk("proto flag", proto_err_o, 1);
    repeat (3) @(negedge clk);
    chk("proto sticky", proto_err_o, 1);
    // Asynchronous reset with groups buffered and a block on the output.
    ready = 0;
    repeat (3) begin
      valid = 2'b11; iaddr = {32'h3008, 32'h3000}; iretire = {32'd2, 32'd2};
      @(negedge clk);
    end
    valid = 0;
    chk("pre-reset valid_o", valid_o, 1);
    #2 rst_n = 0;
    #1;
    chk("async reset valid_o", valid_o, 0);
    chk("async reset ready_o", ready_o, 1);
    chk("async reset overflow", overflow_o, 0);
    @(negedge clk);
    rst_n = 1;
    ready = 1;
    repeat (5) begin
      @(negedge clk);
      chk("no stale block", valid_o, 0);
    end
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      valid = r < 3 ? 2'b00 : r < 6 ? 2'b01 : r < 9 ? 2'b11 : 2'b10;
      ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      iretire = {32'($urandom_range(0, 20)), 32'($urandom_range(0, 20))};
      iaddr = {$urandom, $urandom};
      tval = {$urandom, $urandom};
      ls = 2'($urandom);
      itype = 6'($urandom);
      cause = 10'($urandom);
      priv = 4'($urandom);
      @(negedge clk);
    end
    valid = 0;
    ready = 1;
    repeat (20) @(negedge clk);
    chk("final drained", valid_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
